// File: rtl/r4_out_reorder_pkg.sv
// Shared constants and types for the radix-4 FFT32 output reorder stage.
package r4_out_reorder_pkg;

    localparam int NB    = 16;
    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int BEATS = N / LANES;
    localparam int AW    = $clog2(N);
    localparam int BW    = $clog2(BEATS);

    typedef enum logic [1:0] {
        BK_FREE,
        BK_FILLING,
        BK_FULL,
        BK_READING
    } bank_st_e;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_st_e;

    // Lane l of beat b holds FFT bin l*BEATS + b.
    function automatic logic [AW-1:0] bin_addr(input int lane, input logic [BW-1:0] beat);
        return AW'(lane * BEATS) + AW'(beat);
    endfunction

endpackage

// File: rtl/r4_bank_ram.sv
// One reorder bank: 32 complex words, written 4 lanes per beat, read one bin per cycle
// through a registered output.
module r4_bank_ram
    import r4_out_reorder_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [BW-1:0]       i_wbeat,
    input  logic [NB*LANES-1:0] i_wdr,
    input  logic [NB*LANES-1:0] i_wdi,
    input  logic                i_re,
    input  logic [AW-1:0]       i_raddr,
    output logic [NB-1:0]       o_rdr,
    output logic [NB-1:0]       o_rdi
);

    logic [2*NB-1:0] r_mem [N];
    logic [2*NB-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int l = 0; l < LANES; l++) begin
                r_mem[bin_addr(l, i_wbeat)] <= {i_wdr[NB*l +: NB], i_wdi[NB*l +: NB]};
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdr = r_q[2*NB-1:NB];
    assign o_rdi = r_q[NB-1:0];

endmodule

// File: rtl/r4_out_reorder.sv
// FFT32 output stage: captures 8x4-lane frames into ping-pong banks and drains
// them serially in natural bin order.
//   state    | meaning
//   RD_IDLE  | no bank being read, outputs idle at 0
//   RD_DRAIN | reading bins 0..31 of r_rd_bank, one per cycle
module r4_out_reorder
    import r4_out_reorder_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [NB*LANES-1:0] DR,
    input  logic [NB*LANES-1:0] DI,
    output logic [NB-1:0]       OR,
    output logic [NB-1:0]       OI,
    output logic                RDY,
    output logic                OVLD,
    output logic                OVF
);

    bank_st_e        r_bank_st [2];
    logic            r_wr_bank;
    logic [BW-1:0]   r_beat;
    logic            r_cap_active;
    rd_st_e          r_rd_state;
    logic            r_rd_bank;
    logic [AW-1:0]   r_rd_addr;
    logic            r_out_bank;
    logic            r_ovld;
    logic            r_rdy;
    logic            r_ovf;

    bank_st_e        w_st_nxt [2];
    logic [1:0]      w_freeing;
    logic [1:0]      w_free_now;
    logic [1:0]      w_full_now;
    logic            w_last_rd;
    logic            w_restart;
    logic            w_new_start;
    logic            w_new_bank;
    logic            w_cap_start;
    logic            w_drop;
    logic            w_wr_bank;
    logic            w_we;
    logic [BW-1:0]   w_wbeat;
    logic            w_complete;
    logic            w_rd_go;
    logic            w_rd_bank;
    logic [NB-1:0]   w_rdr0, w_rdi0, w_rdr1, w_rdi1;

    // A bank being freed or completed this cycle counts as free/full already, so
    // coincident events neither drop a frame nor insert a read bubble.
    always_comb begin
        w_last_rd = (r_rd_state == RD_DRAIN) && (r_rd_addr == AW'(N - 1));
        w_freeing  = '0;
        w_free_now = '0;
        for (int i = 0; i < 2; i++) begin
            w_freeing[i]  = w_last_rd && (r_rd_bank == 1'(i));
            w_free_now[i] = (r_bank_st[i] == BK_FREE) || w_freeing[i];
        end

        w_restart   = START && r_cap_active;
        w_new_start = START && !r_cap_active && (|w_free_now);
        w_drop      = START && !r_cap_active && !(|w_free_now);
        w_new_bank  = w_free_now[r_wr_bank] ? r_wr_bank : ~r_wr_bank;
        w_cap_start = w_restart || w_new_start;
        w_wr_bank   = w_new_start ? w_new_bank : r_wr_bank;
        w_we        = w_cap_start || r_cap_active;
        w_wbeat     = START ? '0 : r_beat;
        w_complete  = r_cap_active && !START && (r_beat == BW'(BEATS - 1));

        w_full_now = '0;
        for (int i = 0; i < 2; i++) begin
            w_full_now[i] = (r_bank_st[i] == BK_FULL) || (w_complete && (r_wr_bank == 1'(i)));
        end

        w_rd_go   = 1'b0;
        w_rd_bank = r_rd_bank;
        if (r_rd_state == RD_IDLE) begin
            w_rd_go   = |w_full_now;
            w_rd_bank = w_full_now[0] ? 1'b0 : 1'b1;
        end else if (w_last_rd) begin
            w_rd_go   = w_full_now[~r_rd_bank];
            w_rd_bank = ~r_rd_bank;
        end

        for (int i = 0; i < 2; i++) begin
            w_st_nxt[i] = r_bank_st[i];
            if (w_freeing[i]) begin
                w_st_nxt[i] = BK_FREE;
            end
            if (w_complete && (r_wr_bank == 1'(i))) begin
                w_st_nxt[i] = BK_FULL;
            end
            if (w_rd_go && (w_rd_bank == 1'(i))) begin
                w_st_nxt[i] = BK_READING;
            end
            if (w_cap_start && (w_wr_bank == 1'(i))) begin
                w_st_nxt[i] = BK_FILLING;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bank_st[0] <= BK_FREE;
            r_bank_st[1] <= BK_FREE;
            r_wr_bank    <= 1'b0;
            r_beat       <= '0;
            r_cap_active <= 1'b0;
            r_rd_state   <= RD_IDLE;
            r_rd_bank    <= 1'b0;
            r_rd_addr    <= '0;
            r_out_bank   <= 1'b0;
            r_ovld       <= 1'b0;
            r_rdy        <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_bank_st[0] <= w_st_nxt[0];
            r_bank_st[1] <= w_st_nxt[1];

            if (w_cap_start) begin
                r_cap_active <= 1'b1;
                r_beat       <= BW'(1);
            end else if (r_cap_active) begin
                r_beat <= r_beat + BW'(1);
                if (r_beat == BW'(BEATS - 1)) begin
                    r_cap_active <= 1'b0;
                end
            end

            if (w_new_start) begin
                r_wr_bank <= w_new_bank;
            end else if (w_complete && w_free_now[~r_wr_bank]) begin
                r_wr_bank <= ~r_wr_bank;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            if (w_rd_go) begin
                r_rd_state <= RD_DRAIN;
                r_rd_bank  <= w_rd_bank;
                r_rd_addr  <= '0;
            end else if (r_rd_state == RD_DRAIN) begin
                r_rd_addr <= r_rd_addr + AW'(1);
                if (w_last_rd) begin
                    r_rd_state <= RD_IDLE;
                end
            end

            r_out_bank <= r_rd_bank;
            r_ovld     <= (r_rd_state == RD_DRAIN);
            r_rdy      <= (r_rd_state == RD_DRAIN) && (r_rd_addr == '0);
        end
    end

    r4_bank_ram u_bank0 (
        .i_clk   (CLK),
        .i_we    (w_we && !w_wr_bank),
        .i_wbeat (w_wbeat),
        .i_wdr   (DR),
        .i_wdi   (DI),
        .i_re    ((r_rd_state == RD_DRAIN) && !r_rd_bank),
        .i_raddr (r_rd_addr),
        .o_rdr   (w_rdr0),
        .o_rdi   (w_rdi0)
    );

    r4_bank_ram u_bank1 (
        .i_clk   (CLK),
        .i_we    (w_we && w_wr_bank),
        .i_wbeat (w_wbeat),
        .i_wdr   (DR),
        .i_wdi   (DI),
        .i_re    ((r_rd_state == RD_DRAIN) && r_rd_bank),
        .i_raddr (r_rd_addr),
        .o_rdr   (w_rdr1),
        .o_rdi   (w_rdi1)
    );

    assign OR   = r_ovld ? (r_out_bank ? w_rdr1 : w_rdr0) : '0;
    assign OI   = r_ovld ? (r_out_bank ? w_rdi1 : w_rdi0) : '0;
    assign RDY  = r_rdy;
    assign OVLD = r_ovld;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_r4_out_reorder.sv
// Directed bench for r4_out_reorder: frame ordering, latency, overflow, restart,
// mid-frame reset and coincident free/start.
module tb_r4_out_reorder;
    import r4_out_reorder_pkg::*;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic                START = 1'b0;
    logic [NB*LANES-1:0] DR = '0;
    logic [NB*LANES-1:0] DI = '0;
    logic [NB-1:0]       t_or, t_oi;
    logic                t_rdy, t_ovld, t_ovf;

    r4_out_reorder dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .DR    (DR),
        .DI    (DI),
        .OR    (t_or),
        .OI    (t_oi),
        .RDY   (t_rdy),
        .OVLD  (t_ovld),
        .OVF   (t_ovf)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] out_q[$];
    int          out_cyc[$];
    int          rdy_cyc[$];
    int          idle_nz = 0;

    always @(negedge CLK) begin
        if (t_ovld) begin
            out_q.push_back({t_or, t_oi});
            out_cyc.push_back(cyc);
        end else if (t_or !== '0 || t_oi !== '0) begin
            idle_nz++;
        end
        if (t_rdy) rdy_cyc.push_back(cyc);
    end

    function automatic logic [31:0] exp_word(input int tag, input int k);
        logic [15:0] r;
        r = 16'(tag * 256 + k);
        return {r, ~r};
    endfunction

    task automatic clear_mon();
        out_q.delete();
        out_cyc.delete();
        rdy_cyc.delete();
        idle_nz = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        START = 1'b0;
        idle(3);
        RST = 1'b1;
        clear_mon();
    endtask

    task automatic drive_beat(input int tag, input int b, input logic st);
        for (int l = 0; l < LANES; l++) begin
            DR[NB*l +: NB] = 16'(tag * 256 + l * 8 + b);
            DI[NB*l +: NB] = ~(16'(tag * 256 + l * 8 + b));
        end
        START = st;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic drive_frame(input int tag, output int t);
        t = cyc;
        for (int b = 0; b < BEATS; b++) drive_beat(tag, b, b == 0);
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({t_or, t_oi} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {t_or, t_oi});
        end
        checks++;
        if ({t_rdy, t_ovld, t_ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags rdy/ovld/ovf got %b exp 000", {t_rdy, t_ovld, t_ovf});
        end
    endtask

    task automatic test_single();
        int t;
        logic [31:0] got;
        int first, last;
        do_reset();
        DR = '0;
        DI = '0;
        drive_frame(0, t);
        idle(45);
        checks++;
        if (rdy_cyc.size() != 1 || rdy_cyc[0] != t + 9) begin
            errors++;
            $display("FAIL single_rdy count %0d first %0d exp 1 at %0d", rdy_cyc.size(),
                     rdy_cyc.size() > 0 ? rdy_cyc[0] : -1, t + 9);
        end
        checks++;
        if (out_q.size() != 32) begin
            errors++;
            $display("FAIL single_ovld_len got %0d exp 32", out_q.size());
        end
        first = out_cyc.size() > 0 ? out_cyc[0] : -1;
        last  = out_cyc.size() > 0 ? out_cyc[out_cyc.size() - 1] : -1;
        checks++;
        if (first != t + 9 || last != t + 40) begin
            errors++;
            $display("FAIL single_window got %0d..%0d exp %0d..%0d", first, last, t + 9, t + 40);
        end
        for (int k = 0; k < 32; k++) begin
            got = (k < out_q.size()) ? out_q[k] : 'x;
            checks++;
            if (got !== exp_word(0, k)) begin
                errors++;
                $display("FAIL single_data bin %0d got %h exp %h", k, got, exp_word(0, k));
            end
        end
        checks++;
        if (t_ovf !== 1'b0 || idle_nz != 0) begin
            errors++;
            $display("FAIL single_ovf_idle ovf %b idle_nz %0d exp 0 0", t_ovf, idle_nz);
        end
    endtask

    task automatic test_back_to_back();
        int t, t0;
        logic [31:0] got;
        int last;
        do_reset();
        t0 = 0;
        for (int f = 0; f < 4; f++) begin
            drive_frame(f + 1, t);
            if (f == 0) t0 = t;
            idle(24);
        end
        idle(50);
        last = out_cyc.size() > 0 ? out_cyc[out_cyc.size() - 1] : -1;
        checks++;
        if (out_q.size() != 128 || out_cyc[0] != t0 + 9 || last != t0 + 136) begin
            errors++;
            $display("FAIL b2b_window len %0d last %0d exp 128 ending %0d", out_q.size(), last, t0 + 136);
        end
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 32; k++) begin
                got = (f * 32 + k < out_q.size()) ? out_q[f * 32 + k] : 'x;
                checks++;
                if (got !== exp_word(f + 1, k)) begin
                    errors++;
                    $display("FAIL b2b_data frame %0d bin %0d got %h exp %h", f, k, got, exp_word(f + 1, k));
                end
            end
        end
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (f >= rdy_cyc.size() || rdy_cyc[f] != t0 + 9 + 32 * f) begin
                errors++;
                $display("FAIL b2b_rdy frame %0d got %0d exp %0d", f,
                         f < rdy_cyc.size() ? rdy_cyc[f] : -1, t0 + 9 + 32 * f);
            end
        end
        checks++;
        if (t_ovf !== 1'b0 || idle_nz != 0) begin
            errors++;
            $display("FAIL b2b_ovf_idle ovf %b idle_nz %0d exp 0 0", t_ovf, idle_nz);
        end
    endtask

    task automatic test_overflow();
        int t0, t1, t2;
        logic [31:0] got;
        int last;
        do_reset();
        drive_frame(1, t0);
        drive_frame(2, t1);
        checks++;
        if (t_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got %b exp 0", t_ovf);
        end
        drive_frame(3, t2);
        checks++;
        if (t_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b exp 1", t_ovf);
        end
        idle(80);
        checks++;
        if (t_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 1", t_ovf);
        end
        last = out_cyc.size() > 0 ? out_cyc[out_cyc.size() - 1] : -1;
        checks++;
        if (out_q.size() != 64 || last != t0 + 72) begin
            errors++;
            $display("FAIL ovf_len got %0d ending %0d exp 64 ending %0d", out_q.size(), last, t0 + 72);
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 32; k++) begin
                got = (f * 32 + k < out_q.size()) ? out_q[f * 32 + k] : 'x;
                checks++;
                if (got !== exp_word(f + 1, k)) begin
                    errors++;
                    $display("FAIL ovf_data frame %0d bin %0d got %h exp %h", f, k, got, exp_word(f + 1, k));
                end
            end
        end
        checks++;
        if (rdy_cyc.size() != 2 || rdy_cyc[0] != t0 + 9 || rdy_cyc[1] != t0 + 41) begin
            errors++;
            $display("FAIL ovf_rdy count %0d exp 2 at %0d,%0d", rdy_cyc.size(), t0 + 9, t0 + 41);
        end
    endtask

    task automatic test_restart();
        int t2;
        logic [31:0] got;
        do_reset();
        drive_beat(5, 0, 1'b1);
        drive_beat(5, 1, 1'b0);
        drive_beat(5, 2, 1'b0);
        drive_frame(6, t2);
        idle(45);
        checks++;
        if (out_q.size() != 32) begin
            errors++;
            $display("FAIL restart_len got %0d exp 32", out_q.size());
        end
        for (int k = 0; k < 32; k++) begin
            got = (k < out_q.size()) ? out_q[k] : 'x;
            checks++;
            if (got !== exp_word(6, k)) begin
                errors++;
                $display("FAIL restart_data bin %0d got %h exp %h", k, got, exp_word(6, k));
            end
        end
        checks++;
        if (rdy_cyc.size() != 1 || rdy_cyc[0] != t2 + 9) begin
            errors++;
            $display("FAIL restart_rdy count %0d exp 1 at %0d", rdy_cyc.size(), t2 + 9);
        end
        checks++;
        if (t_ovf !== 1'b0) begin
            errors++;
            $display("FAIL restart_ovf got %b exp 0", t_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int t, t1, t2, t3;
        logic [31:0] got;
        do_reset();
        drive_frame(7, t);
        drive_frame(8, t1);
        drive_frame(9, t2);
        goto_cycle(t + 53);
        checks++;
        if ({t_or, t_oi} !== exp_word(8, 12) || t_ovld !== 1'b1 || t_ovf !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre data %h ovld %b ovf %b exp %h 1 1", {t_or, t_oi}, t_ovld, t_ovf,
                     exp_word(8, 12));
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({t_or, t_oi, t_rdy, t_ovld, t_ovf} !== 35'h0) begin
            errors++;
            $display("FAIL rstmid_zero data %h rdy %b ovld %b ovf %b exp all 0", {t_or, t_oi}, t_rdy,
                     t_ovld, t_ovf);
        end
        idle(2);
        RST = 1'b1;
        clear_mon();
        drive_frame(10, t3);
        idle(45);
        checks++;
        if (out_q.size() != 32 || rdy_cyc.size() != 1 || rdy_cyc[0] != t3 + 9) begin
            errors++;
            $display("FAIL rstmid_after len %0d rdy count %0d exp 32 and rdy at %0d", out_q.size(),
                     rdy_cyc.size(), t3 + 9);
        end
        for (int k = 0; k < 32; k++) begin
            got = (k < out_q.size()) ? out_q[k] : 'x;
            checks++;
            if (got !== exp_word(10, k)) begin
                errors++;
                $display("FAIL rstmid_data bin %0d got %h exp %h", k, got, exp_word(10, k));
            end
        end
        checks++;
        if (t_ovf !== 1'b0 || idle_nz != 0) begin
            errors++;
            $display("FAIL rstmid_ovf_idle ovf %b idle_nz %0d exp 0 0", t_ovf, idle_nz);
        end
    endtask

    task automatic test_coincident();
        int t0, t1, t2;
        logic [31:0] got;
        int last;
        do_reset();
        drive_frame(9, t0);
        drive_frame(10, t1);
        goto_cycle(t0 + 39);
        drive_frame(11, t2);
        idle(80);
        checks++;
        if (t_ovf !== 1'b0) begin
            errors++;
            $display("FAIL coinc_ovf got %b exp 0", t_ovf);
        end
        last = out_cyc.size() > 0 ? out_cyc[out_cyc.size() - 1] : -1;
        checks++;
        if (out_q.size() != 96 || last != t0 + 104) begin
            errors++;
            $display("FAIL coinc_len got %0d ending %0d exp 96 ending %0d", out_q.size(), last, t0 + 104);
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 32; k++) begin
                got = (f * 32 + k < out_q.size()) ? out_q[f * 32 + k] : 'x;
                checks++;
                if (got !== exp_word(9 + f, k)) begin
                    errors++;
                    $display("FAIL coinc_data frame %0d bin %0d got %h exp %h", f, k, got, exp_word(9 + f, k));
                end
            end
        end
        checks++;
        if (rdy_cyc.size() != 3 || rdy_cyc[2] != t0 + 73) begin
            errors++;
            $display("FAIL coinc_rdy count %0d exp 3 with last at %0d", rdy_cyc.size(), t0 + 73);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_coincident();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
